// File: rtl/seven_seg_if.sv
// seven_seg_if: digit inputs and display pin outputs of the seven-segment scanner.
//   thousands/hundreds/tens/ones : BCD digits 3..0 (digit 3 most significant)
//   blank_lz                     : 1 = blank leading zeros
//   dp_en[3:0]                   : per-digit decimal point enable, bit i = digit i
//   an[3:0]                      : anodes, active-low, an[0] = ones
//   seg[6:0]                     : cathodes {g,f,e,d,c,b,a}, active-low
//   dp                           : decimal-point cathode, active-low
// master = digit source / display consumer, slave = scanner.
interface seven_seg_if;
  logic [3:0] thousands;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blank_lz;
  logic [3:0] dp_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output thousands, hundreds, tens, ones, blank_lz, dp_en,
    input  an, seg, dp
  );

  modport slave (
    input  thousands, hundreds, tens, ones, blank_lz, dp_en,
    output an, seg, dp
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 4-digit common-anode seven-segment driver.
// Snapshots the digits once per scan frame, lights one digit per refresh slot
// after a one-cycle all-off guard, and optionally blanks leading zeros.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : seven_seg_if.slave (digit inputs in, an/seg/dp registered out)
// Parameter:
//   REFRESH_DIV : clock cycles per digit slot (>= 2)
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  seven_seg_if.slave  bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Active-low segment patterns {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] pat;
    unique case (code)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0][3:0]  r_snap;
  logic             r_snap_blank;
  logic [3:0]       r_snap_dp;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_cnt_last;
  logic             w_frame_end;
  logic [3:0]       w_blank;
  logic             w_lit;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;

  // Next display values from the current counter, index and snapshot.
  always_comb begin
    w_cnt_last  = (r_cnt == CNT_MAX);
    w_frame_end = w_cnt_last && (r_idx == 2'd3);

    // Zero-blanking cascades down from the most significant digit; digit 0 always shows.
    w_blank[3] = r_snap_blank && (r_snap[3] == 4'd0);
    w_blank[2] = w_blank[3]   && (r_snap[2] == 4'd0);
    w_blank[1] = w_blank[2]   && (r_snap[1] == 4'd0);
    w_blank[0] = 1'b0;

    w_lit     = (r_cnt != '0) && !w_blank[r_idx];
    w_an_nxt  = 4'hF;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if (w_lit) begin
      w_an_nxt  = ~(4'b0001 << r_idx);
      w_seg_nxt = f_decode(r_snap[r_idx]);
      w_dp_nxt  = ~r_snap_dp[r_idx];
    end
  end

  // Scan counters, frame-end snapshot capture and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_snap       <= '0;
      r_snap_blank <= 1'b0;
      r_snap_dp    <= 4'd0;
      r_an         <= 4'hF;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
    end else begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
      if (w_cnt_last) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_frame_end) begin
        r_snap       <= {bus.thousands, bus.hundreds, bus.tens, bus.ones};
        r_snap_blank <= bus.blank_lz;
        r_snap_dp    <= bus.dp_en;
      end
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule
